// File: rtl/alu_issue_station.sv
// Reservation station and single-issue scheduler for the integer ALU.
// Holds dispatched micro-ops until both operands are known, snoops the ALU
// and load/store result buses for tag wake-up, and issues the lowest-index
// ready entry each cycle through registered ALU input ports.
module alu_issue_station #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             disp_valid,
    input  logic [5:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_valid,
    input  logic             disp_qk_valid,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [TAG_W-1:0] disp_dest,
    output logic             rs_full,
    input  logic             alu_cdb_valid,
    input  logic [TAG_W-1:0] alu_cdb_tag,
    input  logic [31:0]      alu_cdb_value,
    input  logic             lsb_cdb_valid,
    input  logic [TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]      lsb_cdb_value,
    output logic             alu_mission,
    output logic [5:0]       alu_op_type,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [TAG_W-1:0] alu_rob_dest
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry state; the payload fields are only meaningful while busy is set.
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_valid;
    logic [RS_SIZE-1:0] qk_valid;
    logic [5:0]         op   [RS_SIZE];
    logic [31:0]        vj   [RS_SIZE];
    logic [31:0]        vk   [RS_SIZE];
    logic [TAG_W-1:0]   qj   [RS_SIZE];
    logic [TAG_W-1:0]   qk   [RS_SIZE];
    logic [TAG_W-1:0]   dest [RS_SIZE];

    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;
    int                 busy_cnt;
    logic               accept;
    logic               advance;

    // rs_full tracks the busy count, so a free entry always exists when accept is high.
    assign accept  = disp_valid && !rs_full;
    assign advance = rdy && !clear;

    // Resolve one operand against both result buses; returns {still_pending, value}.
    // If both buses carry the same tag the ALU bus takes precedence.
    function automatic logic [32:0] snoop(input logic pend, input logic [TAG_W-1:0] tag,
                                          input logic [31:0] val);
        if (pend && alu_cdb_valid && (alu_cdb_tag == tag))
            return {1'b0, alu_cdb_value};
        if (pend && lsb_cdb_valid && (lsb_cdb_tag == tag))
            return {1'b0, lsb_cdb_value};
        return {pend, val};
    endfunction

    // Priority-select the lowest ready entry to issue and the lowest free entry to fill.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        busy_cnt    = 0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy[i] && !qj_valid[i] && !qk_valid[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i])
                free_idx = IDX_W'(i);
            if (busy[i])
                busy_cnt = busy_cnt + 1;
        end
    end

    // Control state: occupancy, full flag and the registered ALU issue port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            rs_full      <= 1'b0;
            alu_mission  <= 1'b0;
            alu_op_type  <= '0;
            alu_rs1      <= '0;
            alu_rs2      <= '0;
            alu_rob_dest <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy        <= '0;
                rs_full     <= 1'b0;
                alu_mission <= 1'b0;
            end else begin
                alu_mission <= issue_found;
                if (issue_found) begin
                    alu_op_type     <= op[issue_idx];
                    alu_rs1         <= vj[issue_idx];
                    alu_rs2         <= vk[issue_idx];
                    alu_rob_dest    <= dest[issue_idx];
                    busy[issue_idx] <= 1'b0;
                end
                if (accept)
                    busy[free_idx] <= 1'b1;
                rs_full <= (busy_cnt + int'(accept) - int'(issue_found)) == RS_SIZE;
            end
        end
    end

    // Entry payload: wake-up of waiting operands and capture of dispatched ops (with bypass).
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {qj_valid[i], vj[i]} <= snoop(qj_valid[i], qj[i], vj[i]);
                    {qk_valid[i], vk[i]} <= snoop(qk_valid[i], qk[i], vk[i]);
                end
            end
            if (accept) begin
                op[free_idx]                     <= disp_op;
                qj[free_idx]                     <= disp_qj;
                qk[free_idx]                     <= disp_qk;
                dest[free_idx]                   <= disp_dest;
                {qj_valid[free_idx], vj[free_idx]} <= snoop(disp_qj_valid, disp_qj, disp_vj);
                {qk_valid[free_idx], vk[free_idx]} <= snoop(disp_qk_valid, disp_qk, disp_vk);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_station.sv
// Self-checking bench for alu_issue_station: directed scenarios followed by
// randomized traffic, all compared against a behavioural reservation-station model.
module tb_alu_issue_station;
    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, clear, disp_valid;
    logic [5:0]       disp_op;
    logic [31:0]      disp_vj, disp_vk;
    logic             disp_qj_valid, disp_qk_valid;
    logic [TAG_W-1:0] disp_qj, disp_qk, disp_dest;
    logic             rs_full;
    logic             alu_cdb_valid, lsb_cdb_valid;
    logic [TAG_W-1:0] alu_cdb_tag, lsb_cdb_tag;
    logic [31:0]      alu_cdb_value, lsb_cdb_value;
    logic             alu_mission;
    logic [5:0]       alu_op_type;
    logic [31:0]      alu_rs1, alu_rs2;
    logic [TAG_W-1:0] alu_rob_dest;

    int total = 0;
    int bad   = 0;

    alu_issue_station #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
        .alu_mission(alu_mission), .alu_op_type(alu_op_type), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_rob_dest(alu_rob_dest)
    );

    always #5 clk = ~clk;

    // Reference model: a bag of waiting micro-ops plus the last issued op.
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [31:0] vj, vk;
        bit        qjv, qkv;
        bit [3:0]  qj, qk, dest;
    } ent_t;

    ent_t      m [RS_SIZE];
    bit        m_mission, m_full;
    bit [5:0]  m_op;
    bit [31:0] m_rs1, m_rs2;
    bit [3:0]  m_dest;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [32:0] operand(bit pend, bit [3:0] tag, bit [31:0] val);
        if (pend && alu_cdb_valid && alu_cdb_tag == tag) return {1'b0, alu_cdb_value};
        if (pend && lsb_cdb_valid && lsb_cdb_tag == tag) return {1'b0, lsb_cdb_value};
        return {pend, val};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
        m_mission = 0; m_full = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_dest = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        ent_t      nxt [RS_SIZE];
        int        iss, fre, cnt;
        bit [32:0] r;
        if (!rdy) return;
        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
            m_mission = 0; m_full = 0;
            return;
        end
        nxt = m;
        iss = -1; fre = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && !m[i].qjv && !m[i].qkv) iss = i;
            if (fre < 0 && !m[i].busy) fre = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m[i].busy) begin
                r = operand(m[i].qjv, m[i].qj, m[i].vj); nxt[i].qjv = r[32]; nxt[i].vj = r[31:0];
                r = operand(m[i].qkv, m[i].qk, m[i].vk); nxt[i].qkv = r[32]; nxt[i].vk = r[31:0];
            end
        end
        m_mission = (iss >= 0);
        if (iss >= 0) begin
            m_op = m[iss].op; m_rs1 = m[iss].vj; m_rs2 = m[iss].vk; m_dest = m[iss].dest;
            nxt[iss].busy = 0;
        end
        if (disp_valid && !m_full && fre >= 0) begin
            nxt[fre].busy = 1; nxt[fre].op = disp_op; nxt[fre].dest = disp_dest;
            nxt[fre].qj = disp_qj; nxt[fre].qk = disp_qk;
            r = operand(disp_qj_valid, disp_qj, disp_vj); nxt[fre].qjv = r[32]; nxt[fre].vj = r[31:0];
            r = operand(disp_qk_valid, disp_qk, disp_vk); nxt[fre].qkv = r[32]; nxt[fre].vk = r[31:0];
        end
        m = nxt;
        cnt = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) cnt++;
        m_full = (cnt == RS_SIZE);
    endtask

    task automatic compare_model();
        check("mission", 32'(alu_mission), 32'(m_mission));
        check("rs_full", 32'(rs_full), 32'(m_full));
        check("op_type", 32'(alu_op_type), 32'(m_op));
        check("rs1", alu_rs1, m_rs1);
        check("rs2", alu_rs2, m_rs2);
        check("rob_dest", 32'(alu_rob_dest), 32'(m_dest));
    endtask

    task automatic idle();
        rdy = 1; clear = 0; disp_valid = 0; disp_op = 0; disp_vj = 0; disp_vk = 0;
        disp_qj_valid = 0; disp_qk_valid = 0; disp_qj = 0; disp_qk = 0; disp_dest = 0;
        alu_cdb_valid = 0; alu_cdb_tag = 0; alu_cdb_value = 0;
        lsb_cdb_valid = 0; lsb_cdb_tag = 0; lsb_cdb_value = 0;
    endtask

    task automatic dispatch(input bit [5:0] op, input bit qjv, input bit [3:0] qj, input bit [31:0] vj,
                            input bit qkv, input bit [3:0] qk, input bit [31:0] vk, input bit [3:0] dst);
        disp_valid = 1; disp_op = op; disp_qj_valid = qjv; disp_qj = qj; disp_vj = vj;
        disp_qk_valid = qkv; disp_qk = qk; disp_vk = vk; disp_dest = dst;
    endtask

    // One clock: model first, then the DUT edge, then sample 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        check("arst_mission", 32'(alu_mission), 0);
        check("arst_full", 32'(rs_full), 0);
        check("arst_rs1", alu_rs1, 0);
        check("arst_dest", 32'(alu_rob_dest), 0);
        model_reset();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_mission", 32'(alu_mission), 0);
        check("reset_full", 32'(rs_full), 0);
        check("reset_op", 32'(alu_op_type), 0);
        check("reset_rs2", alu_rs2, 0);
        rst = 0;

        // Independent ADD: issues one edge after dispatch, strobe lasts one cycle.
        dispatch(28, 0, 0, 5, 0, 0, 7, 3); cycle();
        idle(); cycle();
        check("add_mission", 32'(alu_mission), 1);
        check("add_rs1", alu_rs1, 5);
        check("add_rs2", alu_rs2, 7);
        check("add_dest", 32'(alu_rob_dest), 3);
        cycle();
        check("add_drop", 32'(alu_mission), 0);

        // SUB waiting on tag 2, woken by the ALU bus.
        dispatch(29, 1, 2, 0, 0, 0, 1, 4); cycle();
        idle(); cycle();
        alu_cdb_valid = 1; alu_cdb_tag = 2; alu_cdb_value = 10; cycle();
        idle(); cycle();
        check("sub_mission", 32'(alu_mission), 1);
        check("sub_rs1", alu_rs1, 10);
        check("sub_rs2", alu_rs2, 1);

        // Dispatch bypass from the load bus.
        dispatch(28, 0, 0, 3, 1, 6, 0, 5);
        lsb_cdb_valid = 1; lsb_cdb_tag = 6; lsb_cdb_value = 32'h80; cycle();
        idle(); cycle();
        check("byp_mission", 32'(alu_mission), 1);
        check("byp_rs2", alu_rs2, 32'h80);
        repeat (2) cycle();

        // Fill all entries on tag 9, drop a 9th dispatch, then drain in index order.
        for (int i = 0; i < RS_SIZE; i++) begin
            dispatch(6'(i + 1), 1, 9, 0, 0, 0, i, 4'(i)); cycle();
        end
        check("full_set", 32'(rs_full), 1);
        dispatch(30, 0, 0, 1, 0, 0, 1, 15); cycle();
        check("full_hold", 32'(rs_full), 1);
        idle(); alu_cdb_valid = 1; alu_cdb_tag = 9; alu_cdb_value = 32'h99; cycle();
        idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            cycle();
            check("drain_mission", 32'(alu_mission), 1);
            check("drain_dest", 32'(alu_rob_dest), i);
            if (i == 0) check("full_drop", 32'(rs_full), 0);
        end
        cycle();
        check("drain_end", 32'(alu_mission), 0);

        // rdy low freezes everything, including a high issue strobe.
        for (int i = 0; i < 3; i++) begin
            dispatch(28, 1, 12, 0, 0, 0, i, 4'(10 + i)); cycle();
        end
        idle(); alu_cdb_valid = 1; alu_cdb_tag = 12; alu_cdb_value = 32'h55; cycle();
        idle(); cycle();
        check("frz_first", 32'(alu_rob_dest), 10);
        for (int k = 0; k < 4; k++) begin
            dispatch(28, 0, 0, 1, 0, 0, 2, 1);
            rdy = 0; lsb_cdb_valid = 1; lsb_cdb_tag = 12; lsb_cdb_value = 7; cycle();
            check("frz_mission", 32'(alu_mission), 1);
            check("frz_dest", 32'(alu_rob_dest), 10);
        end
        idle(); cycle();
        check("frz_next", 32'(alu_rob_dest), 11);
        cycle();
        check("frz_last", 32'(alu_rob_dest), 12);
        cycle();
        check("frz_done", 32'(alu_mission), 0);

        // Flush with a simultaneous dispatch: nothing survives.
        for (int i = 0; i < 4; i++) begin
            dispatch(29, 1, 13, 0, 0, 0, i, 4'(i)); cycle();
        end
        dispatch(28, 0, 0, 1, 0, 0, 1, 14); clear = 1; cycle();
        check("clr_mission", 32'(alu_mission), 0);
        check("clr_full", 32'(rs_full), 0);
        idle(); alu_cdb_valid = 1; alu_cdb_tag = 13; alu_cdb_value = 1; cycle();
        idle(); cycle();
        check("clr_absent", 32'(alu_mission), 0);
        cycle();
        check("clr_absent2", 32'(alu_mission), 0);

        // Randomized traffic with occasional stalls, flushes and async resets.
        for (int n = 0; n < 4000; n++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            clear         = ($urandom_range(0, 59) == 0);
            disp_valid    = ($urandom_range(0, 9) < 6);
            disp_op       = 6'($urandom_range(1, 37));
            disp_vj       = $urandom;
            disp_vk       = $urandom;
            disp_qj_valid = $urandom_range(0, 1);
            disp_qk_valid = $urandom_range(0, 1);
            disp_qj       = 4'($urandom_range(0, 5));
            disp_qk       = 4'($urandom_range(0, 5));
            disp_dest     = 4'($urandom);
            alu_cdb_valid = ($urandom_range(0, 9) < 3);
            alu_cdb_tag   = 4'($urandom_range(0, 5));
            alu_cdb_value = $urandom;
            lsb_cdb_valid = ($urandom_range(0, 9) < 3);
            lsb_cdb_tag   = 4'($urandom_range(0, 5));
            lsb_cdb_value = $urandom;
            cycle();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_station.md
# alu_issue_station

Reservation station and issue scheduler for the integer ALU. It buffers dispatched ALU/branch micro-ops until both operands are available, snoops the two result buses (ALU and load/store) for tag wake-up, and issues at most one ready entry per cycle to the combinational ALU by driving its mission/op/operand/destination inputs from registers. It sits between the decoder/dispatch stage and the ALU; flushes come from the ROB.

## Interface
- RS_SIZE, 8, number of entries (power of two, 2..16)
- TAG_W, 4, ROB tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low = hold all state
- clear  in  1  ROB flush (mispredict); synchronous
- disp_valid  in  1  dispatch request
- disp_op  in  6  op code, same encoding as ALU op_type (LUI=1 … AND=37)
- disp_vj / disp_vk  in  32  operand values when ready
- disp_qj_valid / disp_qk_valid  in  1  1 = operand pending on tag
- disp_qj / disp_qk  in  TAG_W  producer ROB tags
- disp_dest  in  TAG_W  destination ROB tag
- rs_full  out  1  no free entry (registered)
- alu_cdb_valid, alu_cdb_tag[TAG_W], alu_cdb_value[32]  in  ALU result broadcast
- lsb_cdb_valid, lsb_cdb_tag[TAG_W], lsb_cdb_value[32]  in  load result broadcast
- alu_mission  out  1  issue strobe to ALU (registered)
- alu_op_type  out  6  issued op
- alu_rs1 / alu_rs2  out  32  issued operands
- alu_rob_dest  out  TAG_W  issued destination tag

## Operation
- Entry state: busy, op, vj, vk, qj_valid, qj, qk_valid, qk, dest.
- Ready = busy & !qj_valid & !qk_valid, evaluated on registered state only.
- Issue: lowest-index ready entry selected; at edge, alu_mission<=1, op/operands/dest loaded, entry busy<=0. No ready entry: alu_mission<=0, other alu_* outputs hold last value.
- Dispatch: if disp_valid & !rs_full, write lowest-index free entry (free at start of cycle; entry freed by issue this cycle not reusable until next cycle).
- Dispatch with rs_full high: ignored, no state change.
- Wake-up: every busy entry with qj_valid & qj==alu_cdb_tag & alu_cdb_valid gets vj<=value, qj_valid<=0; same for lsb bus and for qk. Both buses may match different fields of one entry in the same cycle; both apply.
- Dispatch bypass: incoming operand whose tag matches a valid CDB broadcast in the same cycle is stored as ready with the broadcast value.
- Same tag on both buses simultaneously: protocol error, ALU bus wins.
- rs_full <= (busy count after this edge's dispatch/issue) == RS_SIZE.
- clear (rdy high): all busy<=0, alu_mission<=0, rs_full<=0; dispatch and wake-up that cycle discarded. clear dominates everything except rst.
- rdy low: no register changes (including alu_mission held at its value).
- Reset values: all entries not busy, alu_mission=0, alu_op_type=0, alu_rs1=0, alu_rs2=0, alu_rob_dest=0, rs_full=0.

## Timing
- Dispatch sampled at edge E0; with operands ready, earliest alu_mission=1 after E1 (1-cycle dispatch-to-issue).
- ALU result visible combinationally in the cycle after issue edge; ROB/CDB consumers sample it at the next edge.
- Dependent op: producer issued at E1, broadcast during cycle E1→E2, consumer woken at E2, issued at E3 (issue every 2 cycles on a dependency chain).
- alu_mission is high for exactly one cycle per issued entry; back-to-back independent issues give continuous high.
- Full: 8 dispatches without issue → rs_full=1 after 8th edge; an issue at edge En drops rs_full after En; dispatch accepted from the following cycle.
- rst assertion mid-operation clears state immediately, independent of clk/rdy.

## Test plan
- Reset then dispatch ADD(op 28) vj=5 vk=7 dest=3 both ready → next edge alu_mission=1, alu_rs1=5, alu_rs2=7, alu_rob_dest=3; following cycle alu_mission=0.
- Dispatch SUB(29) qj pending tag 2, vk=1 dest=4; two cycles later alu_cdb_valid tag=2 value=10 → issue one edge after broadcast with alu_rs1=10, alu_rs2=1.
- Dispatch with disp_qk=6 in same cycle as lsb_cdb_valid tag=6 value=0x80 → entry issues next edge with alu_rs2=0x80 (bypass).
- 8 dispatches of ops pending on tag 9 → rs_full=1; 9th dispatch dropped; broadcast tag 9 → entries issue lowest index first, one per cycle, rs_full=0 after first issue.
- Fill 3 ready entries, hold rdy=0 for 4 cycles → outputs and state frozen; rdy=1 resumes issue in index order.
- 4 pending entries, assert clear with simultaneous dispatch → next cycle no busy entries, alu_mission=0, rs_full=0, dispatched op absent.
